// File: rtl/switch_debounce_pkg.sv
// switch_debounce_pkg: shared state encoding and default timing for the switch debouncer.
package switch_debounce_pkg;
  typedef enum logic {STABLE, PENDING} db_state_t;
  localparam int DEFAULT_STABLE_CYCLES = 120000;
  localparam int SIM_STABLE_CYCLES = 8;
endpackage

// File: rtl/debounce_bank.sv
// debounce_bank: two-flop synchronizer plus whole-bank debounce FSM for one switch bank.
module debounce_bank
  import switch_debounce_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  localparam int CNT_W = $clog2(STABLE_CYCLES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw,
  output logic [WIDTH-1:0] db,
  output logic             chg,
  output logic             pending
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);
  db_state_t        state_q, state_d;
  logic [WIDTH-1:0] sync1_q, sync1_d, sync2_q, sync2_d, cand_q, cand_d, db_q, db_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             chg_q, chg_d;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= STABLE;
      sync1_q <= '0;
      sync2_q <= '0;
      cand_q  <= '0;
      db_q    <= '0;
      cnt_q   <= '0;
      chg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cand_q  <= cand_d;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
      chg_q   <= chg_d;
    end
  end
  always_comb begin
    sync1_d = sw;
    sync2_d = sync1_q;
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = '0;
    db_d    = db_q;
    chg_d   = 1'b0;
    if (state_q == STABLE) begin
      if (sync2_q != db_q) begin
        cand_d  = sync2_q;
        state_d = PENDING;
      end
    end else if (sync2_q == db_q) begin
      state_d = STABLE;
    end else if (sync2_q != cand_q) begin
      cand_d = sync2_q;
    end else if (cnt_q == LAST) begin
      db_d    = cand_q;
      chg_d   = 1'b1;
      state_d = STABLE;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end
  assign db      = db_q;
  assign chg     = chg_q;
  assign pending = (state_q == PENDING);
endmodule

// File: rtl/switch_debounce.sv
// switch_debounce: debounces two DIP-switch banks independently and flags when either is settling.
module switch_debounce
  import switch_debounce_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  localparam int CNT_W = $clog2(STABLE_CYCLES)
) (
  input  logic             Clk,
  input  logic             nReset,
  input  logic [WIDTH-1:0] SwA,
  input  logic [WIDTH-1:0] SwB,
  output logic [WIDTH-1:0] DbA,
  output logic [WIDTH-1:0] DbB,
  output logic             ChgA,
  output logic             ChgB,
  output logic             Busy
);
  logic pend_a, pend_b;
  debounce_bank #(.WIDTH(WIDTH), .STABLE_CYCLES(STABLE_CYCLES)) u_bank_a (
    .clk(Clk), .rst_n(nReset), .sw(SwA), .db(DbA), .chg(ChgA), .pending(pend_a)
  );
  debounce_bank #(.WIDTH(WIDTH), .STABLE_CYCLES(STABLE_CYCLES)) u_bank_b (
    .clk(Clk), .rst_n(nReset), .sw(SwB), .db(DbB), .chg(ChgB), .pending(pend_b)
  );
  assign Busy = pend_a | pend_b;
endmodule

// File: tb/tb_switch_debounce.sv
// tb_switch_debounce: directed checks of debounce latency, glitch/bounce rejection, retarget and async reset.
module tb_switch_debounce;
  import switch_debounce_pkg::*;
  logic       clk = 1'b0;
  logic       nreset = 1'b0;
  logic [3:0] sw_a = 4'h0, sw_b = 4'h0, db_a, db_b;
  logic       chg_a, chg_b, busy;
  int         errors = 0, checks = 0;

  switch_debounce #(.WIDTH(4), .STABLE_CYCLES(SIM_STABLE_CYCLES)) dut (
    .Clk(clk), .nReset(nreset), .SwA(sw_a), .SwB(sw_b),
    .DbA(db_a), .DbB(db_b), .ChgA(chg_a), .ChgB(chg_b), .Busy(busy)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // 1: non-zero switches out of reset
    sw_a = 4'hF;
    cyc(3);
    chk("rst_dba", {4'h0, db_a}, 8'h00);
    chk("rst_dbb", {4'h0, db_b}, 8'h00);
    chk("rst_chg", {6'h0, chg_a, chg_b}, 8'h00);
    chk("rst_busy", {7'h0, busy}, 8'h00);
    nreset = 1'b1;
    cyc(2);
    chk("t1_busy_e1", {7'h0, busy}, 8'h00);
    cyc(1);
    chk("t1_busy_e2", {7'h0, busy}, 8'h01);
    cyc(7);
    chk("t1_dba_e9", {4'h0, db_a}, 8'h00);
    chk("t1_chga_e9", {7'h0, chg_a}, 8'h00);
    cyc(1);
    chk("t1_dba_e10", {4'h0, db_a}, 8'h0F);
    chk("t1_chga_e10", {7'h0, chg_a}, 8'h01);
    chk("t1_dbb_e10", {4'h0, db_b}, 8'h00);
    chk("t1_chgb_e10", {7'h0, chg_b}, 8'h00);
    cyc(1);
    chk("t1_chga_e11", {7'h0, chg_a}, 8'h00);
    chk("t1_busy_e11", {7'h0, busy}, 8'h00);
    // 2: clean simultaneous step on both banks
    sw_a = 4'h0;
    cyc(12);
    chk("t2_dba_zero", {4'h0, db_a}, 8'h00);
    sw_a = 4'h5;
    sw_b = 4'hA;
    cyc(2);
    chk("t2_busy_e1", {7'h0, busy}, 8'h00);
    cyc(1);
    chk("t2_busy_e2", {7'h0, busy}, 8'h01);
    cyc(7);
    chk("t2_dbs_e9", {db_a, db_b}, 8'h00);
    chk("t2_busy_e9", {7'h0, busy}, 8'h01);
    cyc(1);
    chk("t2_dbs_e10", {db_a, db_b}, 8'h5A);
    chk("t2_chg_e10", {6'h0, chg_a, chg_b}, 8'h03);
    chk("t2_busy_e10", {7'h0, busy}, 8'h00);
    cyc(1);
    chk("t2_chg_e11", {6'h0, chg_a, chg_b}, 8'h00);
    // 3: bounce, then settle on 5
    sw_a = 4'h0;
    sw_b = 4'h0;
    cyc(12);
    chk("t3_dbs_zero", {db_a, db_b}, 8'h00);
    for (int i = 0; i < 8; i++) begin
      sw_a = (i % 2 == 0) ? 4'h5 : 4'h0;
      for (int j = 0; j < 3; j++) begin
        cyc(1);
        chk("t3_bounce", {3'h0, chg_a, db_a}, 8'h00);
      end
    end
    sw_a = 4'h5;
    cyc(10);
    chk("t3_dba_e9", {4'h0, db_a}, 8'h00);
    cyc(1);
    chk("t3_dba_e10", {4'h0, db_a}, 8'h05);
    chk("t3_chga_e10", {7'h0, chg_a}, 8'h01);
    cyc(1);
    chk("t3_chga_e11", {7'h0, chg_a}, 8'h00);
    // 4: short glitch is rejected
    sw_a = 4'h0;
    cyc(12);
    chk("t4_dba_zero", {4'h0, db_a}, 8'h00);
    sw_a = 4'h3;
    cyc(4);
    sw_a = 4'h0;
    cyc(2);
    chk("t4_busy_e5", {7'h0, busy}, 8'h01);
    cyc(1);
    chk("t4_busy_e6", {7'h0, busy}, 8'h00);
    for (int i = 0; i < 12; i++) begin
      cyc(1);
      chk("t4_glitch", {3'h0, chg_a, db_a}, 8'h00);
    end
    // 5: retarget from 3 to 6 before commit
    sw_a = 4'h3;
    cyc(5);
    sw_a = 4'h6;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      chk("t5_hold", {3'h0, chg_a, db_a}, 8'h00);
    end
    cyc(1);
    chk("t5_dba_e10", {4'h0, db_a}, 8'h06);
    chk("t5_chga_e10", {7'h0, chg_a}, 8'h01);
    // 6: asynchronous reset mid-PENDING
    sw_a = 4'h5;
    cyc(12);
    chk("t6_dba_five", {4'h0, db_a}, 8'h05);
    sw_a = 4'h9;
    cyc(7);
    chk("t6_busy_cnt4", {7'h0, busy}, 8'h01);
    #2 nreset = 1'b0;
    #1;
    chk("t6_async_dba", {4'h0, db_a}, 8'h00);
    chk("t6_async_busy_chg", {6'h0, busy, chg_a}, 8'h00);
    cyc(1);
    chk("t6_held_dba", {4'h0, db_a}, 8'h00);
    nreset = 1'b1;
    cyc(10);
    chk("t6_dba_e9", {4'h0, db_a}, 8'h00);
    cyc(1);
    chk("t6_dba_e10", {4'h0, db_a}, 8'h09);
    chk("t6_chga_e10", {7'h0, chg_a}, 8'h01);
    cyc(1);
    chk("t6_chga_e11", {7'h0, chg_a}, 8'h00);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
